// File: rtl/turn_req_cond.sv
// Turn-stalk conditioner: synchronise and debounce both stalk switches, then hold a direction
// request until the sequencer acknowledges it. Define TURN_TIMEOUT_EN for sweep-count auto-cancel.
module turn_req_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int CNT_W       = 5,
    parameter int MAX_SEQ     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic [5:0] lights,
    output logic [1:0] direction,
    output logic       conflict,
    output logic       timeout
);

    if (SYNC_STAGES < 2 || DEB_CYCLES < 1 || (2 ** CNT_W) <= DEB_CYCLES || MAX_SEQ < 1) begin : gBadParams
        $error("turn_req_cond: illegal parameter combination");
    end

`ifdef TURN_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, RIGHT, LEFT, CONFLICT, HOLDOFF} state_e;
    localparam int SEQ_W = $clog2(MAX_SEQ + 1);
`else
    typedef enum logic [1:0] {IDLE, RIGHT, LEFT, CONFLICT} state_e;
`endif

    // Channel 0 is the right switch, channel 1 the left switch.
    logic [1:0]                  rawSw;
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0]                  deb_q;
    logic [1:0][CNT_W-1:0]       cnt_q;

    state_e     state_q, state_d;
    logic       ack_q;
    logic       ackSeen;
    logic       ownHeld;
    logic [1:0] direction_q;
    logic       conflict_q;

    assign rawSw   = {sw_left, sw_right};
    assign ackSeen = ack_q | (lights != 6'd0);

    // The debounced value flips on the cycle the mismatch run would reach DEB_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            deb_q  <= '0;
            cnt_q  <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], rawSw[ch]};
                if (sync_q[ch][SYNC_STAGES-1] == deb_q[ch]) begin
                    cnt_q[ch] <= '0;
                end else if (cnt_q[ch] == CNT_W'(DEB_CYCLES - 1)) begin
                    deb_q[ch] <= sync_q[ch][SYNC_STAGES-1];
                    cnt_q[ch] <= '0;
                end else begin
                    cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

`ifdef TURN_TIMEOUT_EN
    logic [SEQ_W-1:0] seqCnt_q;
    logic [SEQ_W-1:0] seqNext;
    logic             lightsNz_q;
    logic             sweepDone;
    logic             timeout_q;

    assign sweepDone = lightsNz_q && (lights == 6'd0);
    assign seqNext   = seqCnt_q + SEQ_W'(sweepDone);
    assign timeout   = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ownHeld = 1'b0;
        case (state_q)
            IDLE: begin
                if (deb_q[0] && deb_q[1]) begin
                    state_d = CONFLICT;
                end else if (deb_q[0]) begin
                    state_d = RIGHT;
                end else if (deb_q[1]) begin
                    state_d = LEFT;
                end
            end
            RIGHT, LEFT: begin
                ownHeld = (state_q == RIGHT) ? deb_q[0] : deb_q[1];
                if (!ownHeld && ackSeen) begin
                    state_d = IDLE;
`ifdef TURN_TIMEOUT_EN
                end else if (ownHeld && seqNext >= SEQ_W'(MAX_SEQ)) begin
                    state_d = HOLDOFF;
`endif
                end
            end
            CONFLICT: begin
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
`ifdef TURN_TIMEOUT_EN
            HOLDOFF: begin
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change together with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            direction_q <= 2'b00;
            conflict_q  <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            seqCnt_q    <= '0;
            lightsNz_q  <= 1'b0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ack_q       <= (state_q == IDLE) ? 1'b0 : ackSeen;
            direction_q <= (state_d == RIGHT) ? 2'b01 : (state_d == LEFT) ? 2'b10 : 2'b00;
            conflict_q  <= (state_d == CONFLICT);
`ifdef TURN_TIMEOUT_EN
            lightsNz_q  <= (lights != 6'd0);
            seqCnt_q    <= (state_q == RIGHT || state_q == LEFT) ? seqNext : '0;
            timeout_q   <= (state_d == HOLDOFF);
`endif
        end
    end

    assign direction = direction_q;
    assign conflict  = conflict_q;

endmodule

// File: tb/tb_turn_req_cond.sv
// Randomised self-checking bench for turn_req_cond with a rule-level reference model and a
// simple sequencer model; the HOLDOFF checks are included when TURN_TIMEOUT_EN is defined.
module tb_turn_req_cond;

    localparam int SYNC_STAGES = 2;
    localparam int DEB_CYCLES  = 16;
    localparam int CNT_W       = 5;
    localparam int MAX_SEQ     = 8;
    localparam int LAT         = SYNC_STAGES + DEB_CYCLES + 1;
    localparam int SWEEP_LEN   = 12;

    localparam int M_IDLE  = 0;
    localparam int M_RIGHT = 1;
    localparam int M_LEFT  = 2;
    localparam int M_CONF  = 3;
    localparam int M_HOLD  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_left;
    logic       sw_right;
    logic [5:0] lights;
    logic [1:0] direction;
    logic       conflict;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mMode;
    bit mDeb[2];
    int mRun[2];
    bit mAck;
    int mSweeps;
    bit mPrevNz;
    bit histR[$];
    bit histL[$];

    // Sequencer model state
    int         seqPos;
    int         waitCnt;
    int         seqDelay;
    int         sweepCount;
    logic [5:0] prevLights;

    turn_req_cond #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W),
        .MAX_SEQ    (MAX_SEQ)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_left  (sw_left),
        .sw_right (sw_right),
        .lights   (lights),
        .direction(direction),
        .conflict (conflict),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no end, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] expDir();
        return (mMode == M_RIGHT) ? 2'b01 : (mMode == M_LEFT) ? 2'b10 : 2'b00;
    endfunction

    task automatic modelReset();
        mMode   = M_IDLE;
        mAck    = 1'b0;
        mSweeps = 0;
        mPrevNz = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            mDeb[ch] = 1'b0;
            mRun[ch] = 0;
        end
        histR.delete();
        histL.delete();
        repeat (SYNC_STAGES) begin
            histR.push_back(1'b0);
            histL.push_back(1'b0);
        end
    endtask

    // One clock edge of behaviour: arbitration from the current debounced values, then debounce.
    task automatic modelStep(input bit rawL, input bit rawR, input logic [5:0] lt);
        bit nz;
        bit own;
        bit synced[2];
        nz = (lt != 6'd0);
        case (mMode)
            M_IDLE: begin
                if (mDeb[0] && mDeb[1]) begin
                    mMode = M_CONF;
                end else if (mDeb[0] || mDeb[1]) begin
                    mMode   = mDeb[0] ? M_RIGHT : M_LEFT;
                    mAck    = 1'b0;
                    mSweeps = 0;
                end
            end
            M_RIGHT, M_LEFT: begin
                own = (mMode == M_RIGHT) ? mDeb[0] : mDeb[1];
                if (nz) mAck = 1'b1;
                if (mPrevNz && !nz) mSweeps++;
                if (!own && mAck) begin
                    mMode = M_IDLE;
                end
`ifdef TURN_TIMEOUT_EN
                else if (own && mSweeps >= MAX_SEQ) begin
                    mMode = M_HOLD;
                end
`endif
            end
            default: begin
                if (!mDeb[0] && !mDeb[1]) mMode = M_IDLE;
            end
        endcase
        mPrevNz = nz;
        synced[0] = histR[SYNC_STAGES-1];
        synced[1] = histL[SYNC_STAGES-1];
        for (int ch = 0; ch < 2; ch++) begin
            if (synced[ch] != mDeb[ch]) begin
                mRun[ch]++;
                if (mRun[ch] == DEB_CYCLES) begin
                    mDeb[ch] = synced[ch];
                    mRun[ch] = 0;
                end
            end else begin
                mRun[ch] = 0;
            end
        end
        histR.push_front(rawR);
        void'(histR.pop_back());
        histL.push_front(rawL);
        void'(histL.pop_back());
    endtask

    // Sequencer: waits seqDelay cycles after a fresh request, then runs SWEEP_LEN nonzero steps
    // and one idle step, repeating while a direction is requested.
    task automatic seqUpdate();
        if (seqPos == 0 && direction != 2'b00) begin
            if (waitCnt >= seqDelay) seqPos = 1;
            else waitCnt++;
        end
        if (seqPos == 0 && direction == 2'b00) waitCnt = 0;
        if (seqPos == 0) begin
            lights = 6'd0;
        end else if (seqPos <= SWEEP_LEN) begin
            lights = 6'(seqPos);
            seqPos++;
        end else begin
            lights = 6'd0;
            seqPos = 0;
        end
    endtask

    task automatic seqReset();
        seqPos     = 0;
        waitCnt    = 0;
        lights     = 6'd0;
        prevLights = 6'd0;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        seqUpdate();
        if (prevLights != 6'd0 && lights == 6'd0) sweepCount++;
        prevLights = lights;
        @(posedge clk);
        modelStep(sw_left, sw_right, lights);
        #1;
        checkOutput("direction", 8'(direction), 8'(expDir()));
        checkOutput("conflict", 8'(conflict), 8'(mMode == M_CONF));
        checkOutput("timeout", 8'(timeout), 8'(mMode == M_HOLD));
    endtask

    task automatic runUntilIdle(input string tag, input int budget);
        int n;
        n = 0;
        repeat (LAT + 2) applyStimulus();
        while ((direction != 2'b00 || lights != 6'd0 || seqPos != 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 8'(n < budget), 8'd1);
    endtask

    initial begin
        int base;
        int n;
        int len;
        int per;
        bit chR;

        reset      = 1'b0;
        sw_left    = 1'b0;
        sw_right   = 1'b0;
        seqDelay   = 0;
        sweepCount = 0;
        seqReset();
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstDirection", 8'(direction), 8'd0);
        checkOutput("rstConflict", 8'(conflict), 8'd0);
        checkOutput("rstTimeout", 8'(timeout), 8'd0);
        #1 reset = 1'b1;

        // Bounce rejection
        for (int i = 0; i < 60; i++) begin
            sw_right = ((i / 3) % 2 == 0);
            applyStimulus();
            checkOutput("bounceDir", 8'(direction), 8'd0);
            checkOutput("bounceConf", 8'(conflict), 8'd0);
        end
        sw_right = 1'b0;
        repeat (30) applyStimulus();

        // Clean hold with repeating sweeps
        seqDelay = 0;
        base     = sweepCount;
        sw_right = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            applyStimulus();
            if (i == LAT - 1) checkOutput("holdLatBefore", 8'(direction), 8'd0);
        end
        checkOutput("holdLat", 8'(direction), 8'd1);
        repeat (60) applyStimulus();
        checkOutput("holdSweeps", 8'(sweepCount - base >= 3), 8'd1);
        sw_right = 1'b0;
        runUntilIdle("holdIdle", 100);

        // Short flick with a slow sequencer start
        seqDelay = 10;
        base     = sweepCount;
        sw_left  = 1'b1;
        repeat (20) applyStimulus();
        checkOutput("flickStillLeft", 8'(direction), 8'd2);
        sw_left = 1'b0;
        runUntilIdle("flickIdle", 100);
        checkOutput("flickSweeps", 8'(sweepCount - base), 8'd1);

        // Conflict entry and exit
        sw_left  = 1'b1;
        sw_right = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            applyStimulus();
            if (i == LAT - 1) checkOutput("confBefore", 8'(conflict), 8'd0);
        end
        checkOutput("confSet", 8'(conflict), 8'd1);
        checkOutput("confDir", 8'(direction), 8'd0);
        sw_left  = 1'b0;
        sw_right = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            applyStimulus();
            if (i == LAT - 1) checkOutput("confHeld", 8'(conflict), 8'd1);
        end
        checkOutput("confClear", 8'(conflict), 8'd0);

        // Asynchronous reset in the middle of a right request
        seqDelay = 0;
        sw_right = 1'b1;
        n = 0;
        while (direction != 2'b01 && n < 40) begin
            applyStimulus();
            n++;
        end
        checkOutput("arReached", 8'(n < 40), 8'd1);
        repeat (5) applyStimulus();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkOutput("arDir", 8'(direction), 8'd0);
        checkOutput("arConf", 8'(conflict), 8'd0);
        seqReset();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("arHoldDir", 8'(direction), 8'd0);
        #1 reset = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            applyStimulus();
            if (i == LAT - 1) checkOutput("arLatBefore", 8'(direction), 8'd0);
        end
        checkOutput("arLat", 8'(direction), 8'd1);
        sw_right = 1'b0;
        runUntilIdle("arIdle", 100);

        // Randomised switch activity against the model
        for (int seg = 0; seg < 40; seg++) begin
            len      = $urandom_range(5, 70);
            seqDelay = $urandom_range(0, 12);
            if ($urandom_range(0, 3) == 0) begin
                per = $urandom_range(1, 6);
                chR = 1'($urandom_range(0, 1));
                for (int i = 0; i < len; i++) begin
                    if (i % per == 0) begin
                        if (chR) sw_right = ~sw_right;
                        else sw_left = ~sw_left;
                    end
                    applyStimulus();
                end
            end else begin
                sw_left  = 1'($urandom_range(0, 1));
                sw_right = 1'($urandom_range(0, 1));
                repeat (len) applyStimulus();
            end
        end
        sw_left  = 1'b0;
        sw_right = 1'b0;
        runUntilIdle("randIdle", 200);

`ifdef TURN_TIMEOUT_EN
        // Auto-cancel after MAX_SEQ sweeps of a held switch
        seqDelay = 0;
        base     = sweepCount;
        sw_left  = 1'b1;
        n = 0;
        while (sweepCount - base < MAX_SEQ && n < 400) begin
            applyStimulus();
            n++;
        end
        checkOutput("toReached", 8'(n < 400), 8'd1);
        checkOutput("toTimeout", 8'(timeout), 8'd1);
        checkOutput("toDir", 8'(direction), 8'd0);
        sw_left = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            applyStimulus();
            if (i == LAT - 1) checkOutput("toHeld", 8'(timeout), 8'd1);
        end
        checkOutput("toRelease", 8'(timeout), 8'd0);
        runUntilIdle("toIdle", 100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/turn_req_cond.md
Name: turn_req_cond

Overview:
Upstream conditioner for the tail-light sequencer. It synchronises and debounces the raw left/right turn-stalk switches and arbitrates them into the 2-bit direction code the sequencer consumes. It reads back the sequencer's 6-bit light state, which lets it hold a request until the sequencer has accepted it. As a result, a short stalk flick still produces one complete sweep.

Parameters:
SYNC_STAGES, 2, flops in each switch synchroniser (minimum 2)
DEB_CYCLES, 16, consecutive stable synchronised cycles needed to accept a switch change (minimum 1)
CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES
MAX_SEQ, 8, completed sweeps before auto-cancel (only with TURN_TIMEOUT_EN)

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  asynchronous, active-low; clears all state immediately
sw_left  input  1  raw left stalk switch, asynchronous, bouncing, active-high
sw_right  input  1  raw right stalk switch, asynchronous, bouncing, active-high
lights  input  6  sequencer light state fed back; 6'b000000 means the sequencer is idle
direction  output  2  to the sequencer: 00 none, 01 right, 10 left; 11 is never driven
conflict  output  1  high while both switches are debounced high
timeout  output  1  high while a held request has been auto-cancelled; tied 0 without the macro

Behaviour:
- Reset (reset=0, async): all synchroniser flops, debounced values, counters, ack flag and FSM are cleared. FSM goes to IDLE. Outputs: direction=00, conflict=0, timeout=0.
- Synchroniser: each switch passes through SYNC_STAGES flops.
- Debounce, per channel:
  - A CNT_W counter increments while the synchronised value differs from the debounced value.
  - Any cycle where they are equal clears the counter.
  - When the counter reaches DEB_CYCLES, the debounced value takes the synchronised value and the counter clears.
- Latency, clean raw edge to direction change: SYNC_STAGES+DEB_CYCLES+1 clocks. This is 19 with defaults.
- FSM states: IDLE, RIGHT, LEFT, CONFLICT, plus HOLDOFF when the macro is compiled in.
- IDLE:
  - deb_right&!deb_left -> RIGHT.
  - deb_left&!deb_right -> LEFT.
  - Both high -> CONFLICT.
  - Otherwise stay.
  - The ack flag clears on every entry to RIGHT or LEFT.
- RIGHT/LEFT:
  - direction = 01 (RIGHT) or 10 (LEFT), registered from the state.
  - The ack flag sets on any cycle where lights != 0.
  - Exit to IDLE only when the own debounced switch is 0 AND ack=1. A release before the sequencer starts therefore keeps the request asserted until the first nonzero lights are seen.
  - The opposite switch is ignored while in RIGHT/LEFT. There is no direct RIGHT<->LEFT transition; at least one cycle is spent in IDLE with direction=00.
- CONFLICT: direction=00, conflict=1. Go to IDLE when both debounced values are 0.
- Outputs are all registered and glitch-free. No combinational path exists from lights to direction.
- Simultaneous events:
  - Both switches debounce high in the same cycle from IDLE -> CONFLICT.
  - Release and ack arriving in the same cycle -> exit that cycle.
- Reset mid-sweep drops direction to 00 immediately. The sequencer's own reset handles its lights.

Optional Feature:
Macro TURN_TIMEOUT_EN.
- With the macro:
  - A sweep counter counts completed sweeps in RIGHT/LEFT. A completed sweep is lights going from nonzero to zero on consecutive cycles.
  - The counter clears on entry to RIGHT/LEFT.
  - When it reaches MAX_SEQ while the switch is still held, the FSM goes to HOLDOFF: direction=00, timeout=1.
  - HOLDOFF -> IDLE when both debounced switches are 0; timeout falls with the exit.
  - A conflict arising in HOLDOFF stays in HOLDOFF.
- Without the macro: no sweep counter, no HOLDOFF state, timeout is constant 0. A held switch repeats sweeps indefinitely.

Test Plan:
- Bounce rejection: sw_right toggled every 3 clocks for 60 clocks, then low -> direction stays 00 and conflict stays 0 throughout.
- Clean hold: sw_right high at cycle 0 and held -> direction=01 at cycle 19. With a sequencer model, sweeps repeat. Release -> direction=00 within 2+16+1 clocks after release, plus wait for ack.
- Short flick: sw_left high 20 clocks, sequencer model delays its first nonzero lights by 10 clocks after direction=10 -> direction stays 10 until lights!=0 is seen and the release is debounced. Then direction=00 and exactly one left sweep occurs.
- Conflict: both switches high together -> conflict=1 and direction=00 at cycle 19. Release both -> conflict=0 and state IDLE.
- Async reset mid-request: reset driven low in the middle of a clock period while direction=01 -> direction=00 and conflict=0 before the next clk edge. Then release reset with sw_right still held -> direction=01 again after 19 clocks.
- TURN_TIMEOUT_EN, MAX_SEQ=8: sw_left held, model completes 8 sweeps -> direction=00 and timeout=1 one clock after the 8th nonzero->zero transition. Release -> timeout=0 after the debounce latency.
